// File: rtl/ctrl_ula.sv
// Sequencer for a small ULA datapath: drives load/clear/shift commands to regX/regY/regZ.
// Optional CTRL_ULA_ABORT_EN adds an abort input that cancels an operation in flight.
//
// state  | meaning
// IDLE   | waiting for start; latches op and n on a legal request
// LDX    | load regX
// LDY    | load regY
// EXEC   | ULA function on regX/regY, result loaded into regZ
// SHIFT  | regY divided once per cycle, n cycles
// CLRALL | clear all three registers
// DONE   | one-cycle completion pulse
module ctrl_ula #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
`ifdef CTRL_ULA_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] n,
    output logic [1:0]       Tx,
    output logic [1:0]       Ty,
    output logic [1:0]       Tz,
    output logic [1:0]       selULA,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] T_CLEAR = 2'd0;
    localparam logic [1:0] T_LOAD  = 2'd1;
    localparam logic [1:0] T_HOLD  = 2'd2;
    localparam logic [1:0] T_DIV   = 2'd3;

    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_CLR = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDX,
        S_LDY,
        S_EXEC,
        S_SHIFT,
        S_CLRALL,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             req;
    logic             legal;
    logic             accept;
    logic             cancel;

    assign req    = (state_q == S_IDLE) && start;
    assign legal  = (op <= OP_CLR);
    assign accept = req && legal;

`ifdef CTRL_ULA_ABORT_EN
    assign cancel = abort && (state_q != S_IDLE) && (state_q != S_DONE);
`else
    assign cancel = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= req && !legal;
            if (accept) begin
                op_q  <= op;
                cnt_q <= n;
            end else if (state_q == S_SHIFT) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (op == OP_CLR) ? S_CLRALL : S_LDX;
                end
            end
            S_LDX:    state_d = S_LDY;
            S_LDY: begin
                if (op_q != OP_SHL) begin
                    state_d = S_EXEC;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_EXEC:   state_d = S_DONE;
            // terminal count: the cycle showing 1 is the last shift
            S_SHIFT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_CLRALL: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (cancel) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        Tx     = T_HOLD;
        Ty     = T_HOLD;
        Tz     = T_HOLD;
        selULA = 2'd0;
        busy   = (state_q != S_IDLE);
        done   = 1'b0;
        err    = err_q;
        case (state_q)
            S_LDX:   Tx = T_LOAD;
            S_LDY:   Ty = T_LOAD;
            S_EXEC: begin
                Tz     = T_LOAD;
                selULA = op_q[1:0];
            end
            S_SHIFT: Ty = T_DIV;
            S_CLRALL: begin
                Tx = T_CLEAR;
                Ty = T_CLEAR;
                Tz = T_CLEAR;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_ula.sv
// Scoreboard bench for ctrl_ula: the driver queues the expected output pattern per cycle,
// the monitor compares every cycle in which the DUT shows any activity.
module tb_ctrl_ula;

    localparam int CNT_W = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [CNT_W-1:0] n;
    logic [1:0]       Tx, Ty, Tz, selULA;
    logic             busy, done, err;
`ifdef CTRL_ULA_ABORT_EN
    logic             abort = 1'b0;
`endif

    ctrl_ula #(.CNT_W(CNT_W)) dut (
        .clock  (clock),
        .reset  (reset),
`ifdef CTRL_ULA_ABORT_EN
        .abort  (abort),
`endif
        .start  (start),
        .op     (op),
        .n      (n),
        .Tx     (Tx),
        .Ty     (Ty),
        .Tz     (Tz),
        .selULA (selULA),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [10:0] outs;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [10:0] idle_v;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [10:0] pack(input logic [1:0] tx, ty, tz, sel,
                                         input logic bs, dn, er);
        return {tx, ty, tz, sel, bs, dn, er};
    endfunction

    function automatic logic [10:0] dut_outs();
        return {Tx, Ty, Tz, selULA, busy, done, err};
    endfunction

    task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input int upto, input logic [10:0] v);
        exp_t e;
        if (c <= upto) begin
            e.cyc  = c;
            e.outs = v;
            q.push_back(e);
        end
    endtask

    // Monitor: any cycle that is not plain idle must match the head of the queue
    initial begin
        exp_t        e;
        logic [10:0] v;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                v = dut_outs();
                if (v !== idle_v) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_activity at cycle %0d: got %h expected idle %h",
                                 cyc, v, idle_v);
                    end else begin
                        e = q.pop_front();
                        if (e.cyc != cyc || v !== e.outs) begin
                            errors++;
                            $display("FAIL sequence: got %h at cycle %0d expected %h at cycle %0d",
                                     v, cyc, e.outs, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // Drive one request from a negedge; queue expected cycles (relative to b=cyc) up to b+upto.
    task automatic issue(input logic [2:0] o, input int nn, input int upto,
                         output int b, output int last);
        b     = cyc;
        start = 1'b1;
        op    = o;
        n     = CNT_W'(nn);
        if (o >= 3'd6) begin
            push(b + 1, b + upto, pack(2, 2, 2, 0, 0, 0, 1));
            last = b + 1;
        end else if (o == 3'd5) begin
            push(b + 1, b + upto, pack(0, 0, 0, 0, 1, 0, 0));
            push(b + 2, b + upto, pack(2, 2, 2, 0, 1, 1, 0));
            last = b + 2;
        end else begin
            push(b + 1, b + upto, pack(1, 2, 2, 0, 1, 0, 0));
            push(b + 2, b + upto, pack(2, 1, 2, 0, 1, 0, 0));
            if (o == 3'd4) begin
                for (int i = 0; i < nn; i++)
                    push(b + 3 + i, b + upto, pack(2, 3, 2, 0, 1, 0, 0));
                push(b + 3 + nn, b + upto, pack(2, 2, 2, 0, 1, 1, 0));
                last = b + 3 + nn;
            end else begin
                push(b + 3, b + upto, pack(2, 2, 1, o[1:0], 1, 0, 0));
                push(b + 4, b + upto, pack(2, 2, 2, 0, 1, 1, 0));
                last = b + 4;
            end
        end
        @(negedge clock);
        start = 1'b0;
        op    = 3'($urandom);
        n     = CNT_W'($urandom);
    endtask

    task automatic settle(input int last);
        wait_cyc(last + 1);
        chk("idle_after_op", dut_outs(), idle_v);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int b, last;
        idle_v = pack(2, 2, 2, 0, 0, 0, 0);
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        n      = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_state", dut_outs(), idle_v);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clock);

        // ADD, then SUB/AND/OR each in the first IDLE cycle after the previous DONE
        issue(3'd0, 0, 99, b, last); settle(last);
        issue(3'd1, 2, 99, b, last); settle(last);
        issue(3'd2, 1, 99, b, last); settle(last);
        issue(3'd3, 3, 99, b, last); settle(last);

        // SHL with n=3, n=0, n=1; inputs scrambled after acceptance
        issue(3'd4, 3, 99, b, last); settle(last);
        issue(3'd4, 0, 99, b, last); settle(last);
        issue(3'd4, 1, 99, b, last); settle(last);
        repeat (3) @(negedge clock);

        // illegal ops, then CLR accepted while err is showing
        issue(3'd6, 0, 99, b, last);
        chk("err_busy_low", {7'd0, busy}, 8'd0);
        issue(3'd5, 0, 99, b, last); settle(last);
        issue(3'd7, 2, 99, b, last);
        repeat (2) @(negedge clock);

        // start re-asserted with SUB throughout an ADD must be ignored
        issue(3'd0, 0, 99, b, last);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            op    = 3'd1;
            @(negedge clock);
        end
        start = 1'b0;
        settle(last);
        repeat (2) @(negedge clock);

        // reset during the second SHIFT cycle
        issue(3'd4, 3, 4, b, last);
        wait_cyc(b + 4);
        reset = 1'b1;
        start = 1'b1;
        op    = 3'd0;
        wait_cyc(b + 5);
        chk("reset_mid_shift", dut_outs(), idle_v);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clock);

`ifdef CTRL_ULA_ABORT_EN
        issue(3'd4, 3, 4, b, last);
        wait_cyc(b + 4);
        abort = 1'b1;
        wait_cyc(b + 5);
        chk("abort_mid_shift", dut_outs(), idle_v);
        abort = 1'b0;
        repeat (2) @(negedge clock);

        issue(3'd2, 0, 1, b, last);
        abort = 1'b1;
        wait_cyc(b + 2);
        chk("abort_in_ldx", dut_outs(), idle_v);
        abort = 1'b0;
        repeat (2) @(negedge clock);

        issue(3'd5, 0, 99, b, last);
        wait_cyc(last);
        abort = 1'b1;
        settle(last);
        abort = 1'b0;
        repeat (2) @(negedge clock);

        abort = 1'b1;
        issue(3'd3, 0, 99, b, last);
        abort = 1'b0;
        settle(last);
        repeat (2) @(negedge clock);
`endif

        // a normal op still completes after the interruptions
        issue(3'd1, 0, 99, b, last); settle(last);
        repeat (4) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected cycles never seen, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_ula.md
CTRL_ULA -- requirements
Module: ctrl_ula

Interface
REQ-001 Parameter CNT_W, default 2, width of the shift-count input n.
REQ-002 clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin one operation; sampled only in IDLE.
REQ-005 op  input  3  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 CLR, 6-7 illegal.
REQ-006 n  input  CNT_W  shift count for SHL; ignored for every other op.
REQ-007 Tx, Ty, Tz  output  2 each  register commands for regX/regY/regZ: 0 CLEAR, 1 LOAD, 2 HOLD, 3 DIV.
REQ-008 selULA  output  2  ULA function select (op[1:0] of the latched op).
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  one-cycle illegal-op pulse.

Function
REQ-012 Outputs SHALL be Moore outputs decoded only from the state register and latched op, with no combinational path from any input.
REQ-013 States SHALL be IDLE, LDX, LDY, EXEC, SHIFT, CLRALL and DONE.
REQ-014 Unless a state below says otherwise: Tx=Ty=Tz=HOLD, selULA=0, busy=1 outside IDLE, done=0, err=0.
REQ-015 IDLE with start=1 and legal op SHALL latch op and n.
REQ-016 From IDLE with start=1, op=CLR SHALL go to CLRALL; other legal ops SHALL go to LDX.
REQ-017 IDLE with start=1 and op 6 or 7 SHALL stay in IDLE and assert err for exactly the next cycle.
REQ-018 IDLE with start=0 SHALL remain in IDLE.
REQ-019 LDX: Tx=LOAD for one cycle, then LDY.
REQ-020 LDY: Ty=LOAD for one cycle; next is EXEC for ops 0-3, SHIFT for SHL with n>0, DONE for SHL with n=0.
REQ-021 EXEC: selULA=latched op[1:0], Tz=LOAD for one cycle, then DONE.
REQ-022 SHIFT: Ty=DIV each cycle, for exactly n cycles.
REQ-023 A down-counter loaded with n SHALL decrement once per SHIFT cycle; SHIFT exits to DONE in the cycle the count equals 1.
REQ-024 CLRALL: Tx=Ty=Tz=CLEAR for one cycle, then DONE.
REQ-025 DONE: done=1, busy=1 for one cycle, then IDLE.
REQ-026 start asserted outside IDLE SHALL be ignored and SHALL not be queued.
REQ-027 A new op SHALL be accepted in the first IDLE cycle after DONE.
REQ-028 Latency, counting the start-sampling edge as cycle 0: done at cycle 4 for ADD/SUB/AND/OR, cycle 3+n for SHL, cycle 2 for CLR.
REQ-029 Changes on op or n after acceptance SHALL not affect the operation in flight.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE, with Tx=Ty=Tz=HOLD, selULA=0, busy=0, done=0, err=0, counter=0 and latched op=0.
REQ-031 Reset SHALL take priority over start and abort in every state, including mid-SHIFT.
REQ-032 No done SHALL be produced for an operation interrupted by reset.

Configuration
REQ-033 Macro CTRL_ULA_ABORT_EN defined: a 1-bit input abort SHALL exist.
REQ-034 With CTRL_ULA_ABORT_EN, abort=1 in any non-IDLE state other than DONE SHALL return to IDLE at the next edge, with all T outputs HOLD in the following cycle and no done pulse.
REQ-035 With CTRL_ULA_ABORT_EN, abort in IDLE or DONE SHALL have no effect.
REQ-036 Macro CTRL_ULA_ABORT_EN undefined: the abort port SHALL be absent and all sequences SHALL complete as in Function.

Verification
REQ-037 Reset 2 cycles, then start=1, op=0 -> Tx=1 cycle1, Ty=1 cycle2, Tz=1 with selULA=0 cycle3, done=1 cycle4, busy=0 cycle5.
REQ-038 start, op=4, n=3 -> Ty=3 in cycles 3,4,5; done in cycle 6; Tz stays 2 throughout.
REQ-039 start, op=4, n=0 -> LDX, LDY, then done in cycle 3 with no Ty=3 cycle.
REQ-040 start, op=6 -> err=1 one cycle, busy stays 0; a following start with op=5 -> Tx=Ty=Tz=0 cycle1, done cycle2.
REQ-041 start re-asserted with op=1 during an ADD -> ignored, selULA=0 in EXEC, one done only.
REQ-042 reset=1 during the 2nd SHIFT cycle of op=4, n=3 -> IDLE next cycle with all T=2 and no done; with CTRL_ULA_ABORT_EN, abort at the same point gives the same result.
